// File: rtl/reg_ctx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_ctx_sequencer_if
// Description : Interface bundle for the register-context sequencer.
//               Groups the interrupt handshake, writeback, register-file and
//               memory signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_ctx_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          int_req;
    logic          int_ack;
    logic          reti_req;
    logic          reti_ack;
    logic          pipe_stall;
    logic          busy;
    logic          err;

    logic          wb_we;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;

    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [2:0]    rf_raddr;
    logic [DW-1:0] rf_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    // Sequencer side
    modport master (
        input  int_req, reti_req, wb_we, wb_addr, wb_data, rf_rdata,
               mem_rdata, mem_ack,
        output int_ack, reti_ack, pipe_stall, busy, err, rf_we, rf_waddr,
               rf_wdata, rf_raddr, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Core / register file / memory side
    modport slave (
        output int_req, reti_req, wb_we, wb_addr, wb_data, rf_rdata,
               mem_rdata, mem_ack,
        input  int_ack, reti_ack, pipe_stall, busy, err, rf_we, rf_waddr,
               rf_wdata, rf_raddr, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/reg_ctx_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_ctx_sequencer
// Description : Interrupt context save/restore engine for r1..r7 of an
//               8x16 register file; owns the register-file write port mux.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_ctx_sequencer #(
    parameter int              DW        = 16,
    parameter int              AW        = 16,
    parameter logic [AW-1:0]   SAVE_BASE = 16'hFF00
) (
    input  wire logic           clk,
    input  wire logic           rst,
    reg_ctx_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SDRAIN  = 3'd1,
        S_SAVE    = 3'd2,
        S_HANDLER = 3'd3,
        S_RDRAIN  = 3'd4,
        S_RESTORE = 3'd5,
        S_RDONE   = 3'd6
    } state_t;

    localparam logic [2:0] c_K_FIRST = 3'd1;
    localparam logic [2:0] c_K_LAST  = 3'd7;

    state_t        r_state;
    logic [2:0]    r_k;
    logic          r_int_ack;
    logic          r_err;

    logic          w_in_save;
    logic          w_in_restore;
    logic          w_mem_active;
    logic          w_wb_blocked;
    logic [AW-1:0] w_slot_addr;
    logic [DW-1:0] w_save_data;

    assign w_in_save    = (r_state == S_SAVE);
    assign w_in_restore = (r_state == S_RESTORE);
    assign w_mem_active = w_in_save | w_in_restore;
    assign w_wb_blocked = bus.wb_we & w_mem_active;
    // Slot k lives at SAVE_BASE+k-1; wraps modulo 2^AW.
    assign w_slot_addr  = SAVE_BASE + AW'(r_k) - AW'(1);
    assign w_save_data  = w_in_save ? bus.rf_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= c_K_FIRST;
            r_int_ack <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_int_ack <= 1'b0;
            if (w_wb_blocked) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.int_req) r_state <= S_SDRAIN;
                end
                S_SDRAIN: begin
                    r_state <= S_SAVE;
                end
                S_SAVE: begin
                    if (bus.mem_ack) begin
                        if (r_k == c_K_LAST) begin
                            r_state   <= S_HANDLER;
                            r_k       <= c_K_FIRST;
                            r_int_ack <= 1'b1;
                        end else begin
                            r_k <= 3'(r_k + 3'd1);
                        end
                    end
                end
                S_HANDLER: begin
                    if (bus.reti_req) r_state <= S_RDRAIN;
                end
                S_RDRAIN: begin
                    r_state <= S_RESTORE;
                end
                S_RESTORE: begin
                    if (bus.mem_ack) begin
                        if (r_k == c_K_LAST) begin
                            r_state <= S_RDONE;
                            r_k     <= c_K_FIRST;
                        end else begin
                            r_k <= 3'(r_k + 3'd1);
                        end
                    end
                end
                S_RDONE: begin
                    r_state <= S_IDLE;
                    r_k     <= c_K_FIRST;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_k     <= c_K_FIRST;
                end
            endcase
        end
    end

    assign bus.int_ack    = r_int_ack;
    assign bus.reti_ack   = (r_state == S_RDONE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.err        = r_err;
    assign bus.pipe_stall = (r_state == S_SDRAIN) | w_in_save |
                            (r_state == S_RDRAIN) | w_in_restore;

    assign bus.mem_req    = w_mem_active;
    assign bus.mem_we     = w_in_save;
    assign bus.mem_addr   = w_mem_active ? w_slot_addr : '0;
    assign bus.mem_wdata  = w_save_data;
    assign bus.rf_raddr   = w_in_save ? r_k : 3'd0;

    // Restore owns the write port; save drops writeback; otherwise pass-through.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = bus.wb_addr;
        bus.rf_wdata = bus.wb_data;
        if (w_in_restore) begin
            bus.rf_we    = bus.mem_ack;
            bus.rf_waddr = r_k;
            bus.rf_wdata = bus.mem_rdata;
        end else if (!w_in_save) begin
            bus.rf_we    = bus.wb_we & (bus.wb_addr != 3'd0);
        end
    end

endmodule
`default_nettype wire

// File: doc/reg_ctx_sequencer.md
# reg_ctx_sequencer

Interrupt context save/restore sequencer for the 8×16-bit register file of the pipelined interrupt-capable core. It owns the register file's read-address and write-port muxes, sitting between pipeline writeback and the register file. On an interrupt it stalls the pipeline and streams r1..r7 to a save area in data memory. On return-from-interrupt it streams them back. r0 is hardwired zero and is never saved or written.

## Interface
- DW, 16, data width (register and memory word)
- AW, 16, memory address width
- SAVE_BASE, 16'hFF00, memory address of saved r1; rk is stored at SAVE_BASE+k-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- int_req  in  1  interrupt request level, held by source until int_ack
- int_ack  out  1  one-cycle pulse: context saved, handler may run
- reti_req  in  1  return request level, held until reti_ack
- reti_ack  out  1  one-cycle pulse: context restored
- pipe_stall  out  1  freeze pipeline fetch/issue
- busy  out  1  state != IDLE
- err  out  1  sticky: pipeline writeback attempted while engine owns write port
- wb_we, wb_addr[2:0], wb_data[DW-1:0]  in  pipeline writeback request
- rf_we  out  1 / rf_waddr  out  3 / rf_wdata  out  DW  register file write port
- rf_raddr  out  3  engine read address (valid during SAVE)
- rf_rdata  in  DW  combinational read data for rf_raddr
- mem_req  out  1 / mem_we  out  1 / mem_addr  out  AW / mem_wdata  out  DW  memory request
- mem_rdata  in  DW / mem_ack  in  1  memory response; same-cycle ack allowed

## Operation
- States: IDLE, SDRAIN, SAVE, HANDLER, RDRAIN, RESTORE, RDONE. 3-bit index k, reset and reload value 1.
- IDLE: int_req → SDRAIN. reti_req is ignored.
- SDRAIN: one cycle. Writeback passes through so in-flight results land. Then → SAVE.
- SAVE: rf_raddr=k, mem_req=1, mem_we=1, mem_addr=SAVE_BASE+k-1, mem_wdata=rf_rdata. Request is held stable until mem_ack. On ack: k<7 → k+1; k=7 → HANDLER, k=1, int_ack pulse.
- HANDLER: writeback passes through. int_req is ignored (no nesting). reti_req → RDRAIN.
- RDRAIN: one-cycle pass-through drain. Then → RESTORE.
- RESTORE: mem_req=1, mem_we=0, mem_addr=SAVE_BASE+k-1. On mem_ack in the same cycle: rf_we=1, rf_waddr=k, rf_wdata=mem_rdata. k=7 → RDONE.
- RDONE: reti_ack=1 for one cycle. Then → IDLE, k=1.
- Write-port mux:
  - In RESTORE, the engine drives the port.
  - Otherwise rf_we = wb_we & (wb_addr!=0), with rf_waddr=wb_addr and rf_wdata=wb_data.
- wb_we=1 in SAVE or RESTORE: the write is dropped, not forwarded, and err is set. err clears only on rst.
- pipe_stall = SDRAIN|SAVE|RDRAIN|RESTORE. busy = state!=IDLE.
- Address arithmetic is modulo 2^AW.

## Timing
- Reset values:
  - State is IDLE and k=1.
  - All outputs are 0, except the write-port pass-through, which follows the mux rule.
  - Reset mid-SAVE/RESTORE aborts immediately: mem_req drops the cycle after rst is sampled. A partial save or restore is discarded and the register file is not cleared by this block.
- Zero-wait memory (mem_ack=1 whenever mem_req):
  - Save: int_req sampled at edge N gives SDRAIN in N+1, SAVE in N+2..N+8, and int_ack plus stall low in N+9.
  - Restore: reti_req sampled at edge M gives RDRAIN in M+1, RESTORE in M+2..M+8, reti_ack in M+9, and IDLE in M+10.
- Each mem_ack wait cycle adds exactly one cycle. Outputs stay constant while waiting.
- int_ack and reti_ack are registered-state decodes, exactly one cycle wide.
- int_req and reti_req both high in IDLE: int_req wins. Both high in HANDLER: reti_req wins.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Preload r1..r7=16'h0011..16'h0077 via wb. Pulse int_req with zero-wait memory. Require:
  - writes to 16'hFF00..FF06 with data 0011..0077;
  - int_ack at N+9;
  - pipe_stall high for exactly 8 cycles.
- In HANDLER, overwrite r1..r7 with 16'hDEAD via wb. Assert reti_req. Require r1..r7 to equal 0011..0077 after reti_ack at M+9, and memory never to be written.
- Memory with 2-cycle ack latency: require mem_addr and mem_wdata to stay stable across the wait cycles, and int_ack at N+9+14.
- Drive wb_we=1, wb_addr=3 during SAVE: require rf_we=0 that cycle, err=1, and err held until rst.
- Assert rst at the SAVE k=4 cycle: require IDLE, mem_req=0, and busy=0 next cycle. A fresh int_req must then restart the save at k=1, address FF00.
- With int_req and reti_req both high in IDLE: require a save starts. Then drive wb_addr=0, wb_we=1 in HANDLER: require rf_we=0.
